// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-4 registered stream demultiplexer.
// The optional per-channel delivered-word counters are enabled by defining
// STREAM_DEMUX_CNT_EN.
package stream_demux_pkg;

  localparam int CH_NUM    = 4;
  localparam int SEL_W     = 2;
  localparam int BUF_DEPTH = 2;
  localparam int OCNT_W    = 8;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [1:0]       cnt_t;

  // Saturating increment for the delivered-word counters (sticks at all ones).
  function automatic logic [OCNT_W-1:0] sat_inc(input logic [OCNT_W-1:0] v);
    return (v == {OCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One output channel of the demultiplexer: a 2-entry FIFO built as a small
// shift structure (entry 0 is always the head), with registered occupancy.
// With STREAM_DEMUX_CNT_EN defined it also keeps a saturating count of
// words handed to the consumer.
module demux_chan_buf
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output cnt_t             cnt,
  output logic [WIDTH-1:0] head
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [OCNT_W-1:0] count
`endif
);

  localparam cnt_t CNT_FULL = cnt_t'(BUF_DEPTH);

  cnt_t             cnt_reg;
  cnt_t             cnt_next;
  logic [WIDTH-1:0] mem_reg [BUF_DEPTH];
  logic             do_push;
  logic             do_pop;

  // A pop is only meaningful when a word is held; a push into a full buffer
  // is blocked upstream, but is masked here as well so the FIFO never corrupts.
  assign do_pop  = pop && (cnt_reg != 2'd0);
  assign do_push = push && (cnt_reg != CNT_FULL);

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_next = cnt_reg;
    case ({do_push, do_pop})
      2'b10:   cnt_next = cnt_reg + 2'd1;
      2'b01:   cnt_next = cnt_reg - 2'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  // Occupancy and storage update; entries shift toward the head on a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (do_pop) begin
        // Head leaves; the new word (if any) lands behind whatever remains.
        mem_reg[0] <= (do_push && (cnt_reg == 2'd1)) ? push_data : mem_reg[1];
        if (do_push && (cnt_reg == CNT_FULL)) begin
          mem_reg[1] <= push_data;
        end
      end else if (do_push) begin
        if (cnt_reg == 2'd0) begin
          mem_reg[0] <= push_data;
        end else begin
          mem_reg[1] <= push_data;
        end
      end
    end
  end

  assign cnt  = cnt_reg;
  assign head = mem_reg[0];

`ifdef STREAM_DEMUX_CNT_EN
  logic [OCNT_W-1:0] count_reg;

  // Count words actually delivered to the consumer, saturating at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (do_pop) begin
      count_reg <= sat_inc(count_reg);
    end
  end

  assign count = count_reg;
`endif

endmodule

// File: rtl/stream_demux_1x4.sv
// Registered 1-to-4 stream demultiplexer with valid/ready on every port.
// Each channel is buffered by its own 2-entry FIFO so a stalled consumer
// only blocks words destined for it. in_ready is derived from registered
// occupancy and in_sel alone, never from out_ready.
// Optional feature macro: STREAM_DEMUX_CNT_EN adds the out_count port.
module stream_demux_1x4
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CH_NUM*WIDTH-1:0]   out_data,
  output logic [CH_NUM-1:0]         out_valid,
  input  logic [CH_NUM-1:0]         out_ready
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [CH_NUM*OCNT_W-1:0]  out_count
`endif
);

  cnt_t             chan_cnt [CH_NUM];
  logic [CH_NUM-1:0] chan_push;
  logic             accept;

  // Ready for the addressed channel unless its buffer is full; held low in reset.
  assign in_ready = !rst && (chan_cnt[in_sel] != cnt_t'(BUF_DEPTH));
  assign accept   = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_chan
      assign chan_push[gi] = accept && (in_sel == sel_t'(gi));
      assign out_valid[gi] = (chan_cnt[gi] != 2'd0);

      demux_chan_buf #(
        .WIDTH(WIDTH)
      ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (chan_push[gi]),
        .push_data(in_data),
        .pop      (out_ready[gi]),
        .cnt      (chan_cnt[gi]),
        .head     (out_data[gi*WIDTH +: WIDTH])
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .count    (out_count[gi*OCNT_W +: OCNT_W])
`endif
      );
    end
  endgenerate

endmodule

// File: tb/tb_stream_demux_1x4.sv
// Self-checking bench for stream_demux_1x4: directed steps followed by random
// traffic, compared every cycle against a queue-based reference model.
// Define STREAM_DEMUX_CNT_EN to also exercise the delivered-word counters.
module tb_stream_demux_1x4;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
`ifdef STREAM_DEMUX_CNT_EN
  logic [31:0]  out_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per channel plus delivered-word counts.
  logic [W-1:0] mq [4][$];
  int           mcount [4];
  bit           after_rst;

  stream_demux_1x4 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .out_count(out_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                       input logic [W-1:0] d, input logic [3:0] rdy);
    logic exp_ready;
    logic exp_v;
    rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = rdy;
    #1;
    exp_ready = !r && (mq[s].size() != 2);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    for (int n = 0; n < 4; n++) begin
      exp_v = (mq[n].size() != 0);
      check($sformatf("out_valid[%0d]", n), {31'd0, out_valid[n]}, {31'd0, exp_v});
      if (exp_v)
        check($sformatf("out_data[%0d]", n), {24'd0, out_data[n*W +: W]}, {24'd0, mq[n][0]});
      else if (after_rst)
        check($sformatf("rst_data[%0d]", n), {24'd0, out_data[n*W +: W]}, 32'd0);
`ifdef STREAM_DEMUX_CNT_EN
      check($sformatf("out_count[%0d]", n), {24'd0, out_count[n*8 +: 8]}, mcount[n]);
`endif
    end
    @(posedge clk);
    if (r) begin
      for (int n = 0; n < 4; n++) begin
        mq[n].delete();
        mcount[n] = 0;
      end
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
        if (mq[n].size() != 0 && rdy[n]) begin
          $display("t=%0t deliver ch%0d data=%02h", $time, n, mq[n][0]);
          void'(mq[n].pop_front());
          if (mcount[n] < 255) mcount[n]++;
        end
      end
      if (v && exp_ready) begin
        $display("t=%0t accept  ch%0d data=%02h", $time, s, d);
        mq[s].push_back(d);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int n = 0; n < 4; n++) mcount[n] = 0;
    after_rst = 1'b0;
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A; out_ready = 4'h0;
    @(posedge clk);
    @(negedge clk);
    after_rst = 1'b1;

    // Reset held 2 cycles with in_valid high.
    cycle(1'b1, 1'b1, 2'd1, 8'h5A, 4'h0);
    cycle(1'b1, 1'b1, 2'd2, 8'h5B, 4'h0);

    // First cycles after release: in_ready high for any select.
    for (int s = 0; s < 4; s++) cycle(1'b0, 1'b0, s[1:0], 8'h00, 4'hF);

    // Routing: one word per channel, back to back.
    for (int s = 0; s < 4; s++) cycle(1'b0, 1'b1, s[1:0], 8'hA0 + 8'(s), 4'hF);
    cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

    // Backpressure on channel 2 while channel 0 keeps flowing.
    cycle(1'b0, 1'b1, 2'd2, 8'h11, 4'b1011);
    cycle(1'b0, 1'b1, 2'd2, 8'h22, 4'b1011);
    cycle(1'b0, 1'b1, 2'd2, 8'h33, 4'b1011);
    cycle(1'b0, 1'b1, 2'd0, 8'h44, 4'b1011);
    cycle(1'b0, 1'b1, 2'd2, 8'h33, 4'b1011);
    cycle(1'b0, 1'b1, 2'd0, 8'h45, 4'b1011);
    cycle(1'b0, 1'b1, 2'd2, 8'h33, 4'hF);
    cycle(1'b0, 1'b1, 2'd2, 8'h33, 4'hF);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

    // Simultaneous push/pop on channel 1 at occupancy 1.
    cycle(1'b0, 1'b1, 2'd1, 8'h01, 4'b1101);
    for (int i = 2; i <= 8; i++) cycle(1'b0, 1'b1, 2'd1, 8'(i), 4'hF);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 2'd1, 8'h00, 4'hF);

    // Mid-operation reset with channels 0 and 3 full.
    cycle(1'b0, 1'b1, 2'd0, 8'hC0, 4'h0);
    cycle(1'b0, 1'b1, 2'd3, 8'hC3, 4'h0);
    cycle(1'b0, 1'b1, 2'd0, 8'hC1, 4'h0);
    cycle(1'b0, 1'b1, 2'd3, 8'hC4, 4'h0);
    cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'hF);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            8'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

`ifdef STREAM_DEMUX_CNT_EN
    // Counter saturation: 300 words on channel 0, 5 on channel 3.
    cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 2'd0, 8'(i), 4'hF);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'd3, 8'(i), 4'hF);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
    check("count_ch0_sat", {24'd0, out_count[7:0]}, 32'd255);
    check("count_ch3", {24'd0, out_count[31:24]}, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
